// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller: FSM encoding,
// timeout default and the instruction/enable constants used on the fetch path.
package if_fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2
    } fetch_state_e;

    localparam int          TIMEOUT_DEF = 255;
    localparam logic [31:0] INS_NOP     = 32'h1500_0000;
    localparam logic        ENABLE      = 1'b1;
    localparam logic        DISABLE     = 1'b0;

endpackage

// File: rtl/if_fetch_ctrl_hold_buf.sv
// One-entry instruction hold buffer: word tag, instruction data, valid and
// bus-error flag, with a combinational tag compare for the current PC.
module if_fetch_ctrl_hold_buf
    import if_fetch_ctrl_pkg::*;
#(
    parameter int TAG_W = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic             i_wr_valid,
    input  logic [TAG_W-1:0] i_wr_tag,
    input  logic [31:0]      i_wr_data,
    input  logic             i_wr_err,
    input  logic [TAG_W-1:0] i_lookup_tag,
    output logic             o_hit,
    output logic [31:0]      o_data,
    output logic             o_err
);

    logic             r_valid;
    logic             r_err;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_data;

    // A fill carries its own validity (already masked by flush/discard upstream).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= DISABLE;
            r_err   <= DISABLE;
        end else if (i_wr_en) begin
            r_valid <= i_wr_valid;
            r_err   <= i_wr_err;
        end else if (i_flush) begin
            r_valid <= DISABLE;
        end
    end

    // Tag and data are only ever observed through r_valid, so they carry no reset.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag  <= i_wr_tag;
            r_data <= i_wr_data;
        end
    end

    assign o_hit  = r_valid && (r_tag == i_lookup_tag);
    assign o_data = r_data;
    assign o_err  = r_err;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch bus controller: serves the IF-stage PC from a one-entry
// hold buffer, or runs a req/grant/ready read and stalls IF until it returns.
module if_fetch_ctrl
    import if_fetch_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_en,
    input  logic              flush,
    output logic [31:0]       insn,
    output logic              fetch_stall,
    output logic              fetch_err,
    output logic              misalign,
    output logic              bus_req,
    output logic [ADDR_W-3:0] bus_addr,
    input  logic              bus_grant,
    input  logic              bus_rdy,
    input  logic [31:0]       bus_rd_data
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    fetch_state_e      r_state;
    fetch_state_e      w_state_nxt;
    logic              r_bus_req;
    logic [ADDR_W-3:0] r_bus_addr;
    logic [7:0]        r_tmo_cnt;
    logic              r_discard;

    logic              w_aligned;
    logic              w_buf_hit;
    logic              w_hit;
    logic              w_miss;
    logic              w_launch;
    logic              w_rd_done;
    logic              w_tmo_done;
    logic              w_fill;
    logic [31:0]       w_hold_data;
    logic              w_hold_err;

    assign w_aligned = (fetch_addr[1:0] == 2'b00);
    assign w_hit     = fetch_en && w_aligned && w_buf_hit;
    assign w_miss    = fetch_en && w_aligned && !w_buf_hit;
    assign w_fill    = w_rd_done || w_tmo_done;

    if_fetch_ctrl_hold_buf #(
        .TAG_W (ADDR_W - 2)
    ) u_hold_buf (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (flush),
        .i_wr_en      (w_fill),
        .i_wr_valid   (!(r_discard || flush)),
        .i_wr_tag     (r_bus_addr),
        .i_wr_data    (w_rd_done ? bus_rd_data : INS_NOP),
        .i_wr_err     (w_tmo_done),
        .i_lookup_tag (fetch_addr[ADDR_W-1:2]),
        .o_hit        (w_buf_hit),
        .o_data       (w_hold_data),
        .o_err        (w_hold_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_launch    = DISABLE;
        w_rd_done   = DISABLE;
        w_tmo_done  = DISABLE;
        case (r_state)
            ST_IDLE: begin
                if (w_miss) begin
                    w_launch    = ENABLE;
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus_grant) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Ready wins over a timeout expiring in the same cycle.
                if (bus_rdy) begin
                    w_rd_done   = ENABLE;
                    w_state_nxt = ST_IDLE;
                end else if (r_tmo_cnt == TMO_LAST) begin
                    w_tmo_done  = ENABLE;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_req  <= DISABLE;
            r_bus_addr <= '0;
            r_tmo_cnt  <= '0;
            r_discard  <= DISABLE;
        end else begin
            if (w_launch) begin
                r_bus_req  <= ENABLE;
                r_bus_addr <= fetch_addr[ADDR_W-1:2];
            end else if (w_fill) begin
                r_bus_req  <= DISABLE;
            end
            if (r_state == ST_REQ && bus_grant) begin
                r_tmo_cnt <= '0;
            end else if (r_state == ST_ACCESS) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            // A flush during an in-flight read lets it finish but keeps its result invalid.
            if (w_fill) begin
                r_discard <= DISABLE;
            end else if (flush && r_state != ST_IDLE) begin
                r_discard <= ENABLE;
            end
        end
    end

    always_comb begin
        insn        = INS_NOP;
        fetch_stall = DISABLE;
        fetch_err   = DISABLE;
        misalign    = DISABLE;
        if (!rst) begin
            misalign = fetch_en && !w_aligned;
            if (w_hit) begin
                insn      = w_hold_data;
                fetch_err = w_hold_err;
            end else if (w_miss) begin
                fetch_stall = ENABLE;
            end
        end
    end

    assign bus_req  = r_bus_req;
    assign bus_addr = r_bus_addr;

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Scoreboard bench for if_fetch_ctrl: a fetch driver predicts each served beat
// from a one-entry cache model, a bus responder plays the memory side.
module tb_if_fetch_ctrl;

    localparam int          TMO = 8;
    localparam logic [31:0] NOP = 32'h1500_0000;

    typedef struct packed {
        logic [31:0] insn;
        logic        err;
        logic        mis;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_addr;
    logic        fetch_en;
    logic        flush;
    logic [31:0] insn;
    logic        fetch_stall;
    logic        fetch_err;
    logic        misalign;
    logic        bus_req;
    logic [29:0] bus_addr;
    logic        bus_grant;
    logic        bus_rdy;
    logic [31:0] bus_rd_data;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_txn    = 0;
    int   gnt_dly  = 0;
    int   rdy_dly  = 0;
    logic rdy_never = 1'b0;
    logic flip_once = 1'b0;
    logic mon_on    = 1'b0;

    exp_t        exp_q[$];
    logic [31:0] mem[logic [29:0]];

    logic        m_valid = 1'b0;
    logic [31:0] m_addr  = 32'h0;
    logic [31:0] m_data  = 32'h0;
    logic        m_err   = 1'b0;

    if_fetch_ctrl #(
        .ADDR_W  (32),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_addr  (fetch_addr),
        .fetch_en    (fetch_en),
        .flush       (flush),
        .insn        (insn),
        .fetch_stall (fetch_stall),
        .fetch_err   (fetch_err),
        .misalign    (misalign),
        .bus_req     (bus_req),
        .bus_addr    (bus_addr),
        .bus_grant   (bus_grant),
        .bus_rdy     (bus_rdy),
        .bus_rd_data (bus_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Backing memory; words not preset get a deterministic address-derived value.
    function automatic logic [31:0] mem_rd(input logic [29:0] w);
        if (!mem.exists(w)) mem[w] = {w[15:0], ~w[15:0]} ^ 32'h1357_9BDF;
        return mem[w];
    endfunction

    // Memory-side responder: grant after gnt_dly REQ cycles, ready after rdy_dly ACCESS cycles.
    initial begin : bus_model
        int cnt;
        int acc;
        int phase;
        logic [29:0] w;
        bus_grant   = 1'b0;
        bus_rdy     = 1'b0;
        bus_rd_data = 32'h0;
        cnt = 0;
        acc = 0;
        phase = 0;
        forever begin
            @(negedge clk);
            bus_grant = 1'b0;
            bus_rdy   = 1'b0;
            if (rst) begin
                phase = 0;
            end else begin
                if (phase == 0 && bus_req) begin
                    phase = 1;
                    cnt   = gnt_dly;
                    n_txn++;
                end else if (phase == 2) begin
                    phase = 3;
                    cnt   = rdy_dly;
                    acc   = 0;
                end
                if (phase == 1) begin
                    chk1("req_held_for_grant", bus_req, 1'b1);
                    if (cnt == 0) begin
                        chk32("bus_addr", {2'b00, bus_addr}, {2'b00, fetch_addr[31:2]});
                        bus_grant = 1'b1;
                        phase = 2;
                    end else begin
                        cnt--;
                    end
                end else if (phase == 3) begin
                    if (rdy_never && !bus_req) begin
                        chk_int("timeout_access_cycles", acc, TMO);
                        phase = 0;
                    end else begin
                        chk1("req_held_in_access", bus_req, 1'b1);
                        acc++;
                        if (!rdy_never && cnt == 0) begin
                            w = bus_addr;
                            bus_rdy     = 1'b1;
                            bus_rd_data = mem_rd(w);
                            if (flip_once) begin
                                mem[w]    = ~mem[w];
                                flip_once = 1'b0;
                            end
                            phase = 0;
                        end else if (cnt > 0) begin
                            cnt--;
                        end
                    end
                end
            end
        end
    end

    // Monitor: every cycle the DUT presents a non-stalled output consumes one prediction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_on && !rst && !fetch_stall) begin
                chk1("output_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk32("insn", insn, e.insn);
                    chk1("fetch_err", fetch_err, e.err);
                    chk1("misalign", misalign, e.mis);
                end
            end
        end
    end

    // One fetch beat: predict from the cache model, drive, wait for the stall to clear.
    task automatic do_fetch(input logic [31:0] a, input logic en, input logic fl,
                            input logic mid_fl, input int g, input int r, input logic never);
        exp_t e;
        int   exp_stall;
        int   exp_txn;
        int   stalls;
        int   txn0;
        logic done;
        gnt_dly   = g;
        rdy_dly   = r;
        rdy_never = never;
        flip_once = mid_fl;
        exp_stall = 0;
        exp_txn   = 0;
        if (!en) begin
            e = '{insn: NOP, err: 1'b0, mis: 1'b0};
        end else if (a[1:0] != 2'b00) begin
            e = '{insn: NOP, err: 1'b0, mis: 1'b1};
        end else if (m_valid && m_addr == a) begin
            e = '{insn: m_data, err: m_err, mis: 1'b0};
        end else begin
            exp_txn = mid_fl ? 2 : 1;
            m_valid = 1'b1;
            m_addr  = a;
            if (never) begin
                m_data    = NOP;
                m_err     = 1'b1;
                exp_stall = 2 + g + TMO;
            end else begin
                m_data    = mid_fl ? ~mem_rd(a[31:2]) : mem_rd(a[31:2]);
                m_err     = 1'b0;
                exp_stall = exp_txn * (3 + g + r);
            end
            e = '{insn: m_data, err: m_err, mis: 1'b0};
        end
        if (fl && exp_txn == 0) m_valid = 1'b0;
        txn0 = n_txn;
        exp_q.push_back(e);
        fetch_addr = a;
        fetch_en   = en;
        flush      = fl;
        stalls     = 0;
        done       = 1'b0;
        for (int k = 0; k < 600 && !done; k++) begin
            @(negedge clk);
            if (!fetch_stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                @(posedge clk);
                #1;
                flush = mid_fl && (k == g + 2);
            end
        end
        chk1("stall_released", done, 1'b1);
        if (!done) exp_q.delete();
        chk_int("stall_cycles", stalls, exp_stall);
        chk_int("bus_transactions", n_txn - txn0, exp_txn);
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    initial begin : main
        logic [31:0] a;
        int          kind;
        rst        = 1'b1;
        fetch_en   = 1'b1;
        fetch_addr = 32'h0000_0102;
        flush      = 1'b0;
        mem[30'h40] = 32'h2008_0005;
        mem[30'h80] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("rst_bus_req", bus_req, 1'b0);
        chk32("rst_bus_addr", {2'b00, bus_addr}, 32'h0);
        chk32("rst_insn", insn, NOP);
        chk1("rst_stall", fetch_stall, 1'b0);
        chk1("rst_fetch_err", fetch_err, 1'b0);
        chk1("rst_misalign", misalign, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        fetch_en = 1'b0;
        mon_on   = 1'b1;

        do_fetch(32'h0000_0100, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        repeat (5) do_fetch(32'h0000_0100, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        do_fetch(32'h0000_0180, 1'b1, 1'b0, 1'b0, 4, 2, 1'b0);

        do_fetch(32'h0000_0300, 1'b1, 1'b0, 1'b0, 0, 0, 1'b1);
        do_fetch(32'h0000_0300, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        do_fetch(32'h0000_0104, 1'b1, 1'b0, 1'b0, 1, 1, 1'b0);
        do_fetch(32'h0000_0104, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);

        do_fetch(32'h0000_0200, 1'b1, 1'b0, 1'b1, 0, 2, 1'b0);

        do_fetch(32'h0000_0102, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        do_fetch(32'h0000_0200, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        do_fetch(32'h0000_0200, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0);
        do_fetch(32'h0000_0200, 1'b1, 1'b0, 1'b0, 0, 1, 1'b0);

        for (int i = 0; i < 80; i++) begin
            kind = int'($urandom_range(0, 9));
            a    = 32'h0000_0400 + (32'($urandom_range(0, 3)) << 2);
            if (kind == 0) begin
                do_fetch(a, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
            end else if (kind == 1) begin
                a[1:0] = 2'($urandom_range(1, 3));
                do_fetch(a, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
            end else begin
                do_fetch(a, 1'b1, ($urandom_range(0, 7) == 0), 1'b0,
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
            end
        end

        // Reset in the middle of a request: outputs forced at once, bus_req drops on the edge.
        mon_on     = 1'b0;
        gnt_dly    = 3;
        rdy_never  = 1'b0;
        fetch_addr = 32'h0000_0600;
        fetch_en   = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        chk1("midrst_stall", fetch_stall, 1'b0);
        chk32("midrst_insn", insn, NOP);
        chk1("midrst_req_before_edge", bus_req, 1'b1);
        @(negedge clk);
        chk1("midrst_req_dropped", bus_req, 1'b0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        fetch_en = 1'b0;
        repeat (2) @(posedge clk);

        chk_int("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
